// File: rtl/textmode_render.sv
// textmode_render: 640x400 text-mode pipeline (VRAM/font fetch, RGB565 palette, aligned sync), 3-cycle latency.
// Define TEXTMODE_CURSOR_EN to build the hardware cursor; otherwise CURSOR_X/CURSOR_Y are ignored.
module textmode_render #(
    parameter int HZ_BACK    = 48,
    parameter int VT_BACK    = 35,
    parameter int HZ_SYNC_AT = 704,
    parameter int VT_SYNC_AT = 447,
    parameter int HZ_WHOLE   = 800,
    parameter int VT_WHOLE   = 449
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [10:0] HCNT,
    input  logic [10:0] VCNT,
    output logic [10:0] VADDR,
    input  logic [15:0] VDATA,
    output logic [11:0] FADDR,
    input  logic [7:0]  FDATA,
    input  logic [6:0]  CURSOR_X,
    input  logic [4:0]  CURSOR_Y,
    output logic [4:0]  VGA_R,
    output logic [5:0]  VGA_G,
    output logic [4:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS
);
    localparam logic [10:0] H0     = 11'(HZ_BACK);
    localparam logic [10:0] H1     = 11'(HZ_BACK + 640);
    localparam logic [10:0] V0     = 11'(VT_BACK);
    localparam logic [10:0] V1     = 11'(VT_BACK + 400);
    localparam logic [10:0] HS_AT  = 11'(HZ_SYNC_AT);
    localparam logic [10:0] VS_AT  = 11'(VT_SYNC_AT);
    localparam logic [10:0] H_LAST = 11'(HZ_WHOLE - 1);
    localparam logic [10:0] V_LAST = 11'(VT_WHOLE - 1);

    logic       act, cur_hit, bit_on;
    logic [9:0] x;
    logic [8:0] y;
    logic       act0, act1, act2, hs0, hs1, hs2, vs0, vs1, vs2, cur0, cur1;
    logic [2:0] px0, px1;
    logic [3:0] gr0, idx2, fg, bg, fg_blink, idx;
    logic [7:0] attr1;
    logic [4:0] frame;

    // X and Y stay below 1024/512 inside the active area, so truncated subtraction is exact there
    always_comb begin
        act = HCNT >= H0 && HCNT < H1 && VCNT >= V0 && VCNT < V1;
        x = HCNT[9:0] - H0[9:0];
        y = VCNT[8:0] - V0[8:0];
    end

`ifdef TEXTMODE_CURSOR_EN
    assign cur_hit = x[9:3] == CURSOR_X && y[8:4] == CURSOR_Y && y[3:1] == 3'b111;
`else
    logic unused_cursor;
    assign cur_hit = 1'b0;
    assign unused_cursor = ^{CURSOR_X, CURSOR_Y};
`endif

    always_comb begin
        fg = attr1[3:0];
        bg = {1'b0, attr1[6:4]};
        bit_on = FDATA[~px1];
        fg_blink = attr1[7] && frame[4] ? bg : fg;
        idx = cur1 && frame[3] ? fg : bit_on ? fg_blink : bg;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            VADDR <= '0;
            FADDR <= '0;
            {act0, act1, act2, cur0, cur1, vs0, vs1, vs2} <= '0;
            {hs0, hs1, hs2} <= '1;
            {px0, px1} <= '0;
            gr0 <= '0;
            attr1 <= '0;
            idx2 <= '0;
            frame <= '0;
        end else begin
            VADDR <= act ? {y[8:4], 6'b0} + {2'b0, y[8:4], 4'b0} + {4'b0, x[9:3]} : '0;
            act0 <= act;
            px0 <= x[2:0];
            gr0 <= y[3:0];
            cur0 <= cur_hit;
            hs0 <= HCNT < HS_AT;
            vs0 <= VCNT >= VS_AT;
            FADDR <= {VDATA[7:0], gr0};
            attr1 <= VDATA[15:8];
            act1 <= act0;
            px1 <= px0;
            cur1 <= cur0;
            hs1 <= hs0;
            vs1 <= vs0;
            idx2 <= idx;
            act2 <= act1;
            hs2 <= hs1;
            vs2 <= vs1;
            if (HCNT == H_LAST && VCNT == V_LAST) frame <= frame + 5'd1;
        end
    end

    always_comb begin
        VGA_R = !act2 ? '0 : idx2[2] ? (idx2[3] ? 5'd31 : 5'd21) : (idx2[3] ? 5'd10 : 5'd0);
        VGA_B = !act2 ? '0 : idx2[0] ? (idx2[3] ? 5'd31 : 5'd21) : (idx2[3] ? 5'd10 : 5'd0);
        VGA_G = !act2 ? '0 : idx2 == 4'd6 ? 6'd21 : idx2[1] ? (idx2[3] ? 6'd63 : 6'd42) : (idx2[3] ? 6'd21 : 6'd0);
        VGA_HS = hs2;
        VGA_VS = vs2;
    end
endmodule

// File: tb/tb_textmode_render.sv
// tb_textmode_render: directed bench for textmode_render with a 3-deep expected-pixel queue.
module tb_textmode_render;
    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic [10:0] HCNT = '0;
    logic [10:0] VCNT = '0;
    logic [10:0] VADDR;
    logic [15:0] VDATA;
    logic [11:0] FADDR;
    logic [7:0]  FDATA;
    logic [6:0]  CURSOR_X = 7'd5;
    logic [4:0]  CURSOR_Y = 5'd2;
    logic [4:0]  VGA_R;
    logic [5:0]  VGA_G;
    logic [4:0]  VGA_B;
    logic        VGA_HS, VGA_VS;

    logic [15:0] vram [2000];
    logic [7:0]  font [4096];

    localparam logic [15:0] PAL [16] = '{
        {5'd0, 6'd0, 5'd0},    {5'd0, 6'd0, 5'd21},   {5'd0, 6'd42, 5'd0},   {5'd0, 6'd42, 5'd21},
        {5'd21, 6'd0, 5'd0},   {5'd21, 6'd0, 5'd21},  {5'd21, 6'd21, 5'd0},  {5'd21, 6'd42, 5'd21},
        {5'd10, 6'd21, 5'd10}, {5'd10, 6'd21, 5'd31}, {5'd10, 6'd63, 5'd10}, {5'd10, 6'd63, 5'd31},
        {5'd31, 6'd21, 5'd10}, {5'd31, 6'd21, 5'd31}, {5'd31, 6'd63, 5'd10}, {5'd31, 6'd63, 5'd31}};
    localparam logic [15:0] WHITE  = {5'd31, 6'd63, 5'd31};
    localparam logic [15:0] BLUE   = {5'd0, 6'd0, 5'd21};
    localparam logic [15:0] GREY   = {5'd21, 6'd42, 5'd21};
    localparam logic [15:0] YELLOW = {5'd31, 6'd63, 5'd10};
    localparam logic [15:0] BLACK  = 16'h0000;

    typedef struct packed {
        logic [17:0] exp;
        logic [10:0] h;
        logic [10:0] v;
    } ent_t;

    ent_t q[$];
    int checks = 0;
    int errors = 0;
    int mframe = 0;

    textmode_render dut (
        .CLOCK(CLOCK), .RESET(RESET), .HCNT(HCNT), .VCNT(VCNT),
        .VADDR(VADDR), .VDATA(VDATA), .FADDR(FADDR), .FDATA(FDATA),
        .CURSOR_X(CURSOR_X), .CURSOR_Y(CURSOR_Y),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS)
    );

    assign VDATA = vram[VADDR];
    assign FDATA = font[FADDR];

    always #5 CLOCK = ~CLOCK;

    function automatic logic [10:0] va_for(int h, int v);
        int x = h - 48;
        int y = v - 35;
        if (x >= 0 && x < 640 && y >= 0 && y < 400) return 11'((y / 16) * 80 + x / 8);
        return 11'd0;
    endfunction

    function automatic logic [17:0] model(int h, int v, int fr);
        logic [15:0] w;
        logic [7:0] g;
        logic [3:0] fgc, bgc, ix;
        int x = h - 48;
        int y = v - 35;
        if (!(x >= 0 && x < 640 && y >= 0 && y < 400)) return {BLACK, h < 704, v >= 447};
        w = vram[(y / 16) * 80 + x / 8];
        g = font[{w[7:0], 4'(y % 16)}];
        fgc = w[11:8];
        bgc = {1'b0, w[14:12]};
        if (w[15] && fr[4]) fgc = bgc;
        ix = g[7 - x % 8] ? fgc : bgc;
`ifdef TEXTMODE_CURSOR_EN
        if (x / 8 == int'(CURSOR_X) && y / 16 == int'(CURSOR_Y) && y % 16 >= 14 && fr[3]) ix = w[11:8];
`endif
        return {PAL[ix], h < 704, v >= 447};
    endfunction

    task automatic step_e(int h, int v, bit lit, logic [15:0] rgb);
        ent_t e;
        RESET = 1'b0;
        HCNT = 11'(h);
        VCNT = 11'(v);
        e.h = HCNT;
        e.v = VCNT;
        e.exp = lit ? {rgb, h < 704, v >= 447} : model(h, v, mframe);
        q.push_back(e);
        if (h == 799 && v == 448) mframe = (mframe + 1) % 32;
        @(posedge CLOCK);
        #1;
        checks++;
        assert (VADDR === va_for(h, v)) else begin
            errors++;
            $error("FAIL vaddr h=%0d v=%0d got %0d expected %0d", h, v, VADDR, va_for(h, v));
        end
        if (q.size() == 3) begin
            e = q.pop_front();
            checks++;
            assert ({VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS} === e.exp) else begin
                errors++;
                $error("FAIL pixel h=%0d v=%0d got rgb=%0d,%0d,%0d hs=%b vs=%b expected rgb=%0d,%0d,%0d hs=%b vs=%b",
                       e.h, e.v, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
                       e.exp[17:13], e.exp[12:7], e.exp[6:2], e.exp[1], e.exp[0]);
            end
        end
    endtask

    task automatic step(int h, int v);
        step_e(h, v, 1'b0, BLACK);
    endtask

    task automatic rst_step(int h, int v);
        RESET = 1'b1;
        HCNT = 11'(h);
        VCNT = 11'(v);
        @(posedge CLOCK);
        #1;
        q.delete();
        mframe = 0;
        checks++;
        assert ({VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VADDR, FADDR} === {16'h0, 1'b1, 1'b0, 11'h0, 12'h0}) else begin
            errors++;
            $error("FAIL reset h=%0d v=%0d got rgb=%0d,%0d,%0d hs=%b vs=%b vaddr=%0d faddr=%0d expected zeros with hs=1",
                   h, v, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VADDR, FADDR);
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0);
    endtask

    task automatic adv(int n);
        idle(3);
        for (int i = 0; i < n; i++) step(799, 448);
        idle(3);
    endtask

    task automatic cursor_cell();
        for (int yy = 45; yy <= 47; yy++)
            for (int h = 87; h <= 96; h++) step(h, 35 + yy);
    endtask

    initial begin
        for (int i = 0; i < 2000; i++) vram[i] = 16'h0000;
        for (int i = 0; i < 4096; i++) font[i] = 8'h00;
        vram[0] = 16'h1F41;
        font[{8'h41, 4'h0}] = 8'h80;
        for (int r = 0; r < 16; r++) font[{8'hDB, 4'(r)}] = 8'hFF;
        for (int i = 0; i < 16; i++) vram[1 + i] = {8'(i), 8'hDB};
        vram[20] = 16'h87DB;
        vram[2 * 80 + 5] = 16'h0E00;
        vram[1999] = 16'h4ADB;

        for (int i = 0; i < 4; i++) rst_step(100 + i, 40);

        for (int h = 44; h < 48; h++) step(h, 35);
        step_e(48, 35, 1'b1, WHITE);
        for (int h = 49; h < 56; h++) step_e(h, 35, 1'b1, BLUE);
        for (int h = 56; h < 61; h++) step(h, 35);

        for (int c = 1; c <= 16; c++) begin
            step(48 + 8 * c, 36);
            step(55 + 8 * c, 36);
        end
        step_e(48 + 8 * 7, 36, 1'b1, {5'd21, 6'd21, 5'd0});
        step_e(48 + 8 * 9, 36, 1'b1, {5'd10, 6'd21, 5'd10});

        for (int h = 700; h <= 708; h++) step(h, 100);
        for (int h = 796; h <= 799; h++) step(h, 446);
        for (int h = 0; h <= 4; h++) step(h, 447);
        for (int h = 0; h <= 2; h++) step(h, 448);
        idle(3);

        for (int h = 684; h <= 690; h++) step(h, 434);
        step_e(687, 434, 1'b1, {5'd10, 6'd63, 5'd10});
        step_e(688, 434, 1'b1, BLACK);

        step_e(208, 35, 1'b1, GREY);
        step(215, 35);
        adv(15);
        step_e(208, 35, 1'b1, GREY);
        adv(1);
        step_e(208, 35, 1'b1, BLACK);
        adv(15);
        step_e(215, 35, 1'b1, BLACK);
        adv(1);
        step_e(208, 35, 1'b1, GREY);

        cursor_cell();
        step_e(88, 81, 1'b1, BLACK);
        adv(8);
        cursor_cell();
`ifdef TEXTMODE_CURSOR_EN
        step_e(88, 81, 1'b1, YELLOW);
        step_e(95, 82, 1'b1, YELLOW);
`else
        step_e(88, 81, 1'b1, BLACK);
        step_e(95, 82, 1'b1, BLACK);
`endif
        idle(3);

        for (int h = 48; h <= 50; h++) rst_step(h, 35);
        for (int h = 44; h < 61; h++) step(h, 35);
        step_e(48, 35, 1'b1, WHITE);
        idle(3);
        step_e(88, 81, 1'b1, BLACK);
        cursor_cell();
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
